// File: rtl/vu_vmu_dcache_responder_if.sv
// ---------------------------------------------------------------------------
// vu_vmu_dcache_responder_if
// Request/response bundle between the VMU (master) and the D$ responder
// (slave).
//   dcachereq_*  : line address, tag, store data/mask, op, valid; ready back
//   dcacheresp_* : one-cycle response pulse carrying tag and load data
// ---------------------------------------------------------------------------
interface vu_vmu_dcache_responder_if;
    logic [27:0]  dcachereq_addr;
    logic [11:0]  dcachereq_tag;
    logic [127:0] dcachereq_data;
    logic [15:0]  dcachereq_wmask;
    logic [3:0]   dcachereq_op;
    logic         dcachereq_val;
    logic         dcachereq_rdy;
    logic [127:0] dcacheresp_data;
    logic [11:0]  dcacheresp_tag;
    logic         dcacheresp_val;

    modport master (
        output dcachereq_addr, dcachereq_tag, dcachereq_data, dcachereq_wmask,
               dcachereq_op, dcachereq_val,
        input  dcachereq_rdy, dcacheresp_data, dcacheresp_tag, dcacheresp_val
    );

    modport slave (
        input  dcachereq_addr, dcachereq_tag, dcachereq_data, dcachereq_wmask,
               dcachereq_op, dcachereq_val,
        output dcachereq_rdy, dcacheresp_data, dcacheresp_tag, dcacheresp_val
    );
endinterface

// File: rtl/vu_vmu_dcache_responder.sv
// ---------------------------------------------------------------------------
// vu_vmu_dcache_responder
// Standalone D$ endpoint behind the VMU. Loads read a 128-bit line array,
// stores byte-merge into it, and every request (load, store or no-op) gets
// exactly one tagged response after a latency picked by addr[0]. Odd lines
// are slower than even lines, so responses may come back out of order.
//
// Ports
//   clk    : sole clock, rising edge
//   reset  : asynchronous, active-low
//   dc     : slave side of vu_vmu_dcache_responder_if
//
// A 15-entry occupancy schedule occ[k] holds the response that emerges k
// cycles from now. A request is only accepted when the slot it would land in
// is free, which guarantees at most one response per cycle.
// ---------------------------------------------------------------------------
module vu_vmu_dcache_responder #(
    parameter int LAT_EVEN = 2,
    parameter int LAT_ODD  = 5,
    parameter int IDX_W    = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    vu_vmu_dcache_responder_if.slave    dc
);

    localparam logic [3:0] LAT_E = 4'(LAT_EVEN);
    localparam logic [3:0] LAT_O = 4'(LAT_ODD);
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;

    logic [127:0]       line_q [2**IDX_W];

    logic [15:1]        occ_val_q,  occ_val_d;
    logic [15:1][11:0]  occ_tag_q,  occ_tag_d;
    logic [15:1][127:0] occ_data_q, occ_data_d;

    logic               resp_val_q,  resp_val_d;
    logic [11:0]        resp_tag_q,  resp_tag_d;
    logic [127:0]       resp_data_q, resp_data_d;

    logic [3:0]         lat;
    logic [IDX_W-1:0]   idx;
    logic               rdy;
    logic               accept;
    logic               is_load;
    logic               is_store;
    logic [127:0]       rdata;
    logic [127:0]       line_wdata;
    logic               line_we;
    logic               unused_addr_hi;

    assign lat      = dc.dcachereq_addr[0] ? LAT_O : LAT_E;
    assign idx      = dc.dcachereq_addr[IDX_W-1:0];
    assign unused_addr_hi = ^dc.dcachereq_addr[27:IDX_W];

    // The slot checked is occ[L] pre-shift, which becomes occ[L-1] after
    // this edge -- exactly where an accepted request would be written.
    assign rdy      = reset & ~occ_val_q[lat];
    assign accept   = dc.dcachereq_val & rdy;
    assign is_load  = (dc.dcachereq_op == OP_LOAD);
    assign is_store = (dc.dcachereq_op == OP_STORE);
    assign rdata    = is_load ? line_q[idx] : '0;
    assign line_we  = accept & is_store;

    always_comb begin
        line_wdata = line_q[idx];
        for (int b = 0; b < 16; b++) begin
            if (dc.dcachereq_wmask[b]) begin
                line_wdata[8*b +: 8] = dc.dcachereq_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        occ_val_d   = '0;
        occ_tag_d   = '0;
        occ_data_d  = '0;
        for (int k = 1; k < 15; k++) begin
            occ_val_d[k]  = occ_val_q[k+1];
            occ_tag_d[k]  = occ_tag_q[k+1];
            occ_data_d[k] = occ_data_q[k+1];
        end
        resp_val_d  = occ_val_q[1];
        resp_tag_d  = occ_tag_q[1];
        resp_data_d = occ_data_q[1];
        if (accept) begin
            if (lat == 4'd1) begin
                // Single-cycle latency bypasses the schedule entirely.
                resp_val_d  = 1'b1;
                resp_tag_d  = dc.dcachereq_tag;
                resp_data_d = rdata;
            end else begin
                occ_val_d[4'(lat - 4'd1)]  = 1'b1;
                occ_tag_d[4'(lat - 4'd1)]  = dc.dcachereq_tag;
                occ_data_d[4'(lat - 4'd1)] = rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_val_q   <= '0;
            occ_tag_q   <= '0;
            occ_data_q  <= '0;
            resp_val_q  <= 1'b0;
            resp_tag_q  <= '0;
            resp_data_q <= '0;
        end else begin
            occ_val_q   <= occ_val_d;
            occ_tag_q   <= occ_tag_d;
            occ_data_q  <= occ_data_d;
            resp_val_q  <= resp_val_d;
            resp_tag_q  <= resp_tag_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Line contents survive reset; only the in-flight schedule is cleared.
    always_ff @(posedge clk) begin
        if (line_we) begin
            line_q[idx] <= line_wdata;
        end
    end

    assign dc.dcachereq_rdy   = rdy;
    assign dc.dcacheresp_val  = resp_val_q;
    assign dc.dcacheresp_tag  = resp_tag_q;
    assign dc.dcacheresp_data = resp_data_q;

endmodule
